game_flow_ctrl: RTL and testbench
=================================

// Module: game_flow_ctrl
// PURPOSE
//  Top-level game sequencer. Turns the player buttons into single-cycle pulses and
//  steps the board generator through CHOSE_BOARD -> GAME_INITIAL -> GAMING -> WINNED.
//  Drives game_status and gen_random into boardGenerator and watches its 12-bit board.
//  Also counts player moves and detects the solved board.
// PARAMETERS
//  BOARD_W      12  board vector width; must match boardGenerator out
//  DEB_CYCLES   4   cycles a synchronised button must stay stable before it is accepted
//  INIT_CYCLES  2   cycles spent in GAME_INITIAL so the generator latches the board
//  MOVE_W       8   move counter width
// PORTS
//  clk          in   1        system clock
//  rst          in   1        async active-high reset
//  btn_confirm  in   1        raw confirm button, asynchronous
//  btn_random   in   1        raw randomise button, asynchronous
//  btn_abort    in   1        raw abort button, asynchronous; returns to board choice
//  board        in   BOARD_W  current board from the generator
//  move_stb     in   1        one-cycle strobe: the player applied one move
//  game_status  out  2        00 CHOSE_BOARD, 01 GAMING, 10 GAME_INITIAL, 11 WINNED
//  gen_random   out  1        one-cycle pulse that asks the generator to randomise
//  move_count   out  MOVE_W   moves made in the current game; saturates at all-ones
//  reject       out  1        one-cycle pulse: confirm was refused because board==0
//  win_led      out  1        high while in WINNED
// BEHAVIOUR
//  Reset (async, rst=1): game_status=CHOSE_BOARD, gen_random=0, move_count=0, reject=0,
//   win_led=0. All synchroniser, debounce and counter state is cleared. Reset may
//   assert mid-game and forces CHOSE_BOARD on the next edge or immediately (async).
//  Buttons: each button passes through a 2-flop synchroniser, then a debouncer. The
//   debounced level changes only after DEB_CYCLES consecutive equal samples. A 1-cycle
//   pulse is produced on the rising edge of the debounced level. Pin-to-pulse latency
//   is 2+DEB_CYCLES+1 cycles. Holding a button gives exactly one pulse.
//  FSM (registered outputs; every transition takes effect on the edge after its pulse):
//   CHOSE_BOARD:
//    - random pulse -> gen_random=1 for exactly 1 cycle; state unchanged.
//    - confirm pulse with board!=0 -> GAME_INITIAL; init counter loaded to INIT_CYCLES-1.
//    - confirm pulse with board==0 -> reject=1 for 1 cycle; stay in CHOSE_BOARD.
//    - confirm and random pulses in the same cycle -> confirm wins; no gen_random.
//   GAME_INITIAL:
//    - counts down; when the counter reaches 0 -> GAMING; move_count cleared to 0.
//    - buttons are ignored; abort is still honoured.
//   GAMING:
//    - each move_stb increments move_count; it saturates at 2^MOVE_W-1.
//    - board==0 (registered compare) -> WINNED. If move_stb occurs in that same cycle,
//      it is still counted.
//    - random pulses are ignored; gen_random is never asserted outside CHOSE_BOARD.
//   WINNED:
//    - win_led=1; move_count frozen; move_stb ignored.
//    - confirm pulse -> CHOSE_BOARD; move_count is held until the next GAME_INITIAL.
//   Any state: abort pulse -> CHOSE_BOARD. Abort has priority over every other event.
//  Encoding 2'b00..2'b11 is fixed as listed; illegal states are unreachable.
// STRUCTURE
//  Shared header game_defs.vh: CHOSE_BOARD/GAMING/GAME_INITIAL/WINNED localparams,
//   BOARD_W default. The same header is used by boardGenerator and the benches.
//  Sub-module btn_pulse (synchroniser + debouncer + edge detector, param DEB_CYCLES),
//   instantiated three times. The FSM, init counter and move counter live in the top.
// TESTING (DEB_CYCLES=4, INIT_CYCLES=2; each button held 10 cycles)
//  1 Reset mid-GAMING with move_count=5 -> game_status=00 and move_count=0 in the same
//    cycle; no gen_random.
//  2 CHOSE_BOARD, press random twice -> exactly two gen_random pulses, each 1 cycle
//    wide, first 7 cycles after the pin rises; game_status stays 00.
//  3 board=12'h0A5, confirm -> 00->10 for 2 cycles ->01, move_count=0; 3 move_stb ->
//    move_count=3; board=0 -> 11, win_led=1.
//  4 board=0, confirm in CHOSE_BOARD -> one-cycle reject, status stays 00;
//    confirm+random same cycle -> 10, no gen_random.
//  5 GAMING, 260 move_stb -> move_count=255; abort -> 00; random in GAMING -> no
//    gen_random.
//  6 Button bounce: 3-cycle glitch trains -> no pulse; WINNED + confirm -> 00,
//    win_led=0.

Source files
------------

// File: rtl/game_flow_ctrl_pkg.sv
// Shared definitions for the game sequencer: state encoding and the default board width.
package game_flow_ctrl_pkg;

   localparam int BOARD_W_DEF = 12;

   typedef enum logic [1:0] {
      CHOSE_BOARD  = 2'b00,
      GAMING       = 2'b01,
      GAME_INITIAL = 2'b10,
      WINNED       = 2'b11
   } game_state_t;

endpackage

// File: rtl/game_flow_ctrl_btn_pulse.sv
// Raw button to single-cycle pulse: 2-flop synchroniser, counting debouncer and
// rising-edge detector on the debounced level.
module btn_pulse #(
   parameter int DEB_CYCLES = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn,
   output logic o_pulse
);

   localparam int CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

   logic [1:0]       r_sync;
   logic             r_deb;
   logic             r_deb_d;
   logic [CNT_W-1:0] r_cnt;

   // r_cnt counts consecutive synchronised samples that disagree with the debounced level
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync  <= '0;
         r_deb   <= 1'b0;
         r_deb_d <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync  <= {r_sync[0], i_btn};
         r_deb_d <= r_deb;
         if (r_sync[1] == r_deb) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
            r_deb <= r_sync[1];
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_pulse = r_deb & ~r_deb_d;

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: button pulses, game FSM, init countdown and move counter
// driving the board generator.
module game_flow_ctrl
   import game_flow_ctrl_pkg::*;
#(
   parameter int BOARD_W     = BOARD_W_DEF,
   parameter int DEB_CYCLES  = 4,
   parameter int INIT_CYCLES = 2,
   parameter int MOVE_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn_confirm,
   input  logic              btn_random,
   input  logic              btn_abort,
   input  logic [BOARD_W-1:0] board,
   input  logic              move_stb,
   output logic [1:0]        game_status,
   output logic              gen_random,
   output logic [MOVE_W-1:0] move_count,
   output logic              reject,
   output logic              win_led
);

   localparam int IW = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES + 1);

   logic w_confirm;
   logic w_random;
   logic w_abort;

   btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_confirm (
      .i_clk(clk), .i_rst(rst), .i_btn(btn_confirm), .o_pulse(w_confirm)
   );
   btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_random (
      .i_clk(clk), .i_rst(rst), .i_btn(btn_random), .o_pulse(w_random)
   );
   btn_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_abort (
      .i_clk(clk), .i_rst(rst), .i_btn(btn_abort), .o_pulse(w_abort)
   );

   game_state_t       r_state;
   logic [IW-1:0]     r_init_cnt;
   logic [MOVE_W-1:0] r_move_cnt;
   logic              r_gen_random;
   logic              r_reject;
   logic              r_board_zero;

   game_state_t       w_state_nxt;
   logic [IW-1:0]     w_init_nxt;
   logic [MOVE_W-1:0] w_move_nxt;
   logic              w_gen_nxt;
   logic              w_rej_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= CHOSE_BOARD;
         r_init_cnt   <= '0;
         r_move_cnt   <= '0;
         r_gen_random <= 1'b0;
         r_reject     <= 1'b0;
         r_board_zero <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_init_cnt   <= w_init_nxt;
         r_move_cnt   <= w_move_nxt;
         r_gen_random <= w_gen_nxt;
         r_reject     <= w_rej_nxt;
         r_board_zero <= (board == '0);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_init_nxt  = r_init_cnt;
      w_move_nxt  = r_move_cnt;
      w_gen_nxt   = 1'b0;
      w_rej_nxt   = 1'b0;
      if (w_abort) begin
         w_state_nxt = CHOSE_BOARD;
      end else begin
         case (r_state)
            CHOSE_BOARD: begin
               // confirm outranks random when both pulse together
               if (w_confirm) begin
                  if (board != '0) begin
                     w_state_nxt = GAME_INITIAL;
                     w_init_nxt  = IW'(INIT_CYCLES - 1);
                  end else begin
                     w_rej_nxt = 1'b1;
                  end
               end else if (w_random) begin
                  w_gen_nxt = 1'b1;
               end
            end
            GAME_INITIAL: begin
               if (r_init_cnt == '0) begin
                  w_state_nxt = GAMING;
                  w_move_nxt  = '0;
               end else begin
                  w_init_nxt = r_init_cnt - IW'(1);
               end
            end
            GAMING: begin
               if (move_stb && (r_move_cnt != '1)) begin
                  w_move_nxt = r_move_cnt + MOVE_W'(1);
               end
               if (r_board_zero) begin
                  w_state_nxt = WINNED;
               end
            end
            WINNED: begin
               if (w_confirm) begin
                  w_state_nxt = CHOSE_BOARD;
               end
            end
            default: w_state_nxt = CHOSE_BOARD;
         endcase
      end
   end

   assign game_status = r_state;
   assign gen_random  = r_gen_random;
   assign reject      = r_reject;
   assign move_count  = r_move_cnt;
   assign win_led     = (r_state == WINNED);

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios plus random soak against a cycle model.
module tb_game_flow_ctrl;

   localparam int BW   = 12;
   localparam int DEB  = 4;
   localparam int INIT = 2;
   localparam int MW   = 8;
   localparam int S_CB = 0;
   localparam int S_GM = 1;
   localparam int S_GI = 2;
   localparam int S_WN = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          btn_confirm;
   logic          btn_random;
   logic          btn_abort;
   logic [BW-1:0] board;
   logic          move_stb;
   logic [1:0]    game_status;
   logic          gen_random;
   logic [MW-1:0] move_count;
   logic          reject;
   logic          win_led;

   game_flow_ctrl #(
      .BOARD_W(BW), .DEB_CYCLES(DEB), .INIT_CYCLES(INIT), .MOVE_W(MW)
   ) dut (
      .clk(clk), .rst(rst), .btn_confirm(btn_confirm), .btn_random(btn_random),
      .btn_abort(btn_abort), .board(board), .move_stb(move_stb),
      .game_status(game_status), .gen_random(gen_random), .move_count(move_count),
      .reject(reject), .win_led(win_led)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int gen_seen, rej_seen, gi_seen;

   // reference model state
   int m_st, m_mc, m_age;
   bit m_gen, m_rej, m_bz;
   bit m_deb   [3];
   bit m_pulse [3];
   bit m_hist  [3][DEB+2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_st = S_CB; m_mc = 0; m_age = 0; m_gen = 0; m_rej = 0; m_bz = 0;
      for (int b = 0; b < 3; b++) begin
         m_deb[b] = 0; m_pulse[b] = 0;
         for (int k = 0; k < DEB + 2; k++) m_hist[b][k] = 0;
      end
   endtask

   // one clock edge of the spec-level behaviour; pulses seen here were produced last edge
   task automatic model_edge();
      bit pin [3];
      bit flip, nd;
      int max_mc;
      max_mc = (1 << MW) - 1;
      pin[0] = btn_confirm; pin[1] = btn_random; pin[2] = btn_abort;
      m_gen = 0; m_rej = 0;
      if (m_pulse[2]) m_st = S_CB;
      else begin
         case (m_st)
            S_CB: begin
               if (m_pulse[0] && board != 0) begin m_st = S_GI; m_age = 0; end
               else if (m_pulse[0]) m_rej = 1;
               else if (m_pulse[1]) m_gen = 1;
            end
            S_GI: begin
               m_age++;
               if (m_age == INIT) begin m_st = S_GM; m_mc = 0; end
            end
            S_GM: begin
               if (move_stb && m_mc < max_mc) m_mc++;
               if (m_bz) m_st = S_WN;
            end
            default: if (m_pulse[0]) m_st = S_CB;
         endcase
      end
      m_bz = (board == 0);
      // window holds pin values for the last DEB+2 edges; the oldest DEB are past the synchroniser
      for (int b = 0; b < 3; b++) begin
         for (int k = 0; k < DEB + 1; k++) m_hist[b][k] = m_hist[b][k+1];
         m_hist[b][DEB+1] = pin[b];
         flip = 1;
         for (int k = 0; k < DEB; k++) if (m_hist[b][k] == m_deb[b]) flip = 0;
         nd = flip ? !m_deb[b] : m_deb[b];
         m_pulse[b] = nd && !m_deb[b];
         m_deb[b] = nd;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) model_edge();
      #1;
      cyc++;
      chk("status", game_status, m_st);
      chk("gen_random", gen_random, m_gen);
      chk("reject", reject, m_rej);
      chk("move_count", move_count, m_mc);
      chk("win_led", win_led, (m_st == S_WN));
      if (gen_random === 1'b1) gen_seen++;
      if (reject === 1'b1) rej_seen++;
      if (game_status === 2'b10) gi_seen++;
   endtask

   task automatic set_pin(input int b, input logic v);
      case (b)
         0: btn_confirm = v;
         1: btn_random  = v;
         default: btn_abort = v;
      endcase
   endtask

   task automatic press(input int b);
      set_pin(b, 1'b1);
      repeat (10) tick();
      set_pin(b, 1'b0);
      repeat (8) tick();
   endtask

   initial begin
      int first;
      rst = 1'b1; btn_confirm = 0; btn_random = 0; btn_abort = 0; board = '0; move_stb = 0;
      #1;
      model_reset();
      chk("rst_status", game_status, 0);
      chk("rst_gen", gen_random, 0);
      chk("rst_mc", move_count, 0);
      chk("rst_reject", reject, 0);
      chk("rst_win", win_led, 0);
      repeat (2) tick();
      rst = 1'b0;

      // 1: async reset mid-GAMING
      board = BW'($urandom_range(1, 4095));
      press(0);
      chk("t1_gaming", game_status, 1);
      move_stb = 1; repeat (5) tick(); move_stb = 0; tick();
      chk("t1_mc5", move_count, 5);
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("t1_async_status", game_status, 0);
      chk("t1_async_mc", move_count, 0);
      chk("t1_async_gen", gen_random, 0);
      repeat (2) tick();
      rst = 1'b0;

      // 2: two random presses in CHOSE_BOARD
      gen_seen = 0; first = -1;
      btn_random = 1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (gen_random === 1'b1 && first < 0) first = i + 1;
      end
      btn_random = 0;
      repeat (8) tick();
      chk("t2_latency", first, 7);
      press(1);
      chk("t2_gen_count", gen_seen, 2);
      chk("t2_status", game_status, 0);

      // 3: full game on 0A5
      board = 12'h0A5; gi_seen = 0;
      press(0);
      chk("t3_gi_cycles", gi_seen, 2);
      chk("t3_gaming", game_status, 1);
      chk("t3_mc0", move_count, 0);
      for (int i = 0; i < 3; i++) begin move_stb = 1; tick(); move_stb = 0; tick(); end
      chk("t3_mc3", move_count, 3);
      board = '0;
      repeat (3) tick();
      chk("t3_winned", game_status, 3);
      chk("t3_led", win_led, 1);

      // 4: reject on empty board, then confirm+random together
      press(0);
      chk("t4_back", game_status, 0);
      rej_seen = 0;
      press(0);
      chk("t4_reject_count", rej_seen, 1);
      chk("t4_status", game_status, 0);
      board = BW'($urandom_range(1, 4095)); gen_seen = 0; gi_seen = 0;
      btn_confirm = 1; btn_random = 1;
      repeat (10) tick();
      btn_confirm = 0; btn_random = 0;
      repeat (8) tick();
      chk("t4_no_gen", gen_seen, 0);
      chk("t4_gi_cycles", gi_seen, 2);

      // 5: saturation, random ignored, abort
      move_stb = 1; repeat (260) tick(); move_stb = 0; tick();
      chk("t5_sat", move_count, 255);
      gen_seen = 0;
      press(1);
      chk("t5_no_gen", gen_seen, 0);
      chk("t5_still_gaming", game_status, 1);
      press(2);
      chk("t5_abort", game_status, 0);

      // 6: glitch trains, then leave WINNED
      press(0);
      board = '0; repeat (3) tick();
      chk("t6_winned", game_status, 3);
      for (int r = 0; r < 5; r++) begin
         btn_confirm = 1; btn_abort = 1; repeat (3) tick();
         btn_confirm = 0; btn_abort = 0; tick();
      end
      repeat (8) tick();
      chk("t6_glitch_status", game_status, 3);
      chk("t6_glitch_led", win_led, 1);
      press(0);
      chk("t6_exit", game_status, 0);
      chk("t6_led_off", win_led, 0);

      // random soak
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0)  btn_confirm = ~btn_confirm;
         if ($urandom_range(0, 5) == 0)  btn_random  = ~btn_random;
         if ($urandom_range(0, 59) == 0) btn_abort   = ~btn_abort;
         if ($urandom_range(0, 15) == 0)
            board = ($urandom_range(0, 3) == 0) ? '0 : BW'($urandom_range(1, 4095));
         move_stb = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 999) == 0) begin
            #2 rst = 1'b1;
            #1;
            model_reset();
            chk("soak_async_status", game_status, 0);
            tick();
            rst = 1'b0;
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
